// File: rtl/multicycle_processor.sv
// -----------------------------------------------------------------------------
// multicycle_processor
//   Multi-cycle MIPS-subset core. One FSM steps every instruction through
//   FETCH/DECODE/EXEC/MEM/WB. Instruction fetch and data access share a
//   single req/ready memory port, so any transfer may take wait states.
//   The core holds a 32x32 register file, an ALU and a sign extender.
//   Supported: add, sub, and, or, slt, lw, sw, beq, bne, addi, j, halt.
//
// Parameters
//   ADDR_WIDTH  byte-address width of the PC and the memory port (3..32)
//   RESET_PC    word-aligned PC loaded on reset
//
// Ports
//   clk        clock; all state changes on the rising edge
//   clr        synchronous active-high reset
//   mem_req    memory request valid
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_rdata  read data, valid when mem_ready is high on a read
//   mem_ready  transfer completes on an edge where mem_req & mem_ready
//   pc_out     current PC (next instruction once FETCH completes)
//   retire     one-cycle pulse per completed instruction
//   halted     core stopped (halt instruction or fault)
//   fault      0 none, 1 illegal opcode/funct, 2 misaligned load/store
//   overflow   sticky signed overflow from add/sub/addi
// -----------------------------------------------------------------------------
module multicycle_processor #(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  retire,
  output logic                  halted,
  output logic [1:0]            fault,
  output logic                  overflow
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [1:0] FAULT_ILLEGAL    = 2'd1;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd2;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           ir, a, b, imm, alu_out, mdr;
  logic [31:0]           rf [32];

  // Instruction fields
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       is_rtype;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign is_rtype = (op == OP_RTYPE);
  assign pc_out   = pc;

  logic legal;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // ALU: second operand is rt for R-type, the immediate for addi.
  logic [31:0] op2, sum, diff, alu_res;
  logic        add_ovf, sub_ovf, alu_ovf;

  always_comb begin
    op2     = is_rtype ? b : imm;
    sum     = a + op2;
    diff    = a - b;
    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // result sign differs from the first operand.
    add_ovf = (a[31] == op2[31]) && (sum[31] != a[31]);
    sub_ovf = (a[31] != b[31])   && (diff[31] != a[31]);
    alu_res = sum;
    alu_ovf = add_ovf;
    if (is_rtype) begin
      case (funct)
        F_SUB:   begin alu_res = diff;  alu_ovf = sub_ovf; end
        F_AND:   begin alu_res = a & b; alu_ovf = 1'b0;    end
        F_OR:    begin alu_res = a | b; alu_ovf = 1'b0;    end
        F_SLT:   begin alu_res = {31'd0, $signed(a) < $signed(b)}; alu_ovf = 1'b0; end
        default: begin alu_res = sum;   alu_ovf = add_ovf; end
      endcase
    end
  end

  // Address arithmetic, all modulo 2^ADDR_WIDTH.
  logic [ADDR_WIDTH-1:0] pc_plus4, ea, br_pc, jump_pc;
  logic                  taken;
  logic [4:0]            wb_dest;
  logic [31:0]           wb_data;

  assign pc_plus4 = pc + ADDR_WIDTH'(4);
  assign ea       = a[ADDR_WIDTH-1:0] + imm[ADDR_WIDTH-1:0];
  assign taken    = (a == b) ^ (op == OP_BNE);
  assign br_pc    = taken ? pc + ADDR_WIDTH'({imm[29:0], 2'b00}) : pc;
  assign jump_pc  = ADDR_WIDTH'({ir[25:0], 2'b00});
  assign wb_dest  = is_rtype ? rd : rt;
  assign wb_data  = (op == OP_LW) ? mdr : alu_out;

  // NOTE: sequential state uses non-blocking assignments only, so every
  //       right-hand side sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= FETCH;
      pc        <= ADDR_WIDTH'(RESET_PC);
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      // NOTE: the register file is cleared on reset; $0 relies on it
      //       because writes to $0 are simply skipped.
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
      fault     <= '0;
      overflow  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        // Raises the request itself when arriving with mem_req low (after
        // reset or right after a store completes); otherwise it is already up.
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir      <= mem_rdata;
            pc      <= pc_plus4;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end

        DECODE: begin
          a   <= rf[rs];
          b   <= rf[rt];
          imm <= {{16{ir[15]}}, ir[15:0]};
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (!legal) begin
            halted <= 1'b1;
            fault  <= FAULT_ILLEGAL;
            state  <= HALT;
          end else begin
            state <= EXEC;
          end
        end

        EXEC: begin
          case (op)
            OP_LW, OP_SW: begin
              if (ea[1:0] != 2'b00) begin
                halted <= 1'b1;
                fault  <= FAULT_MISALIGNED;
                state  <= HALT;
              end else begin
                mem_req   <= 1'b1;
                mem_we    <= (op == OP_SW);
                mem_addr  <= ea;
                mem_wdata <= b;
                state     <= MEM;
              end
            end
            OP_BEQ, OP_BNE: begin
              pc       <= br_pc;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= br_pc;
              retire   <= 1'b1;
              state    <= FETCH;
            end
            OP_J: begin
              pc       <= jump_pc;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= jump_pc;
              retire   <= 1'b1;
              state    <= FETCH;
            end
            default: begin
              alu_out <= alu_res;
              if (alu_ovf) overflow <= 1'b1;
              state <= WB;
            end
          endcase
        end

        MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              retire <= 1'b1;
              state  <= FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= WB;
            end
          end
        end

        WB: begin
          if (wb_dest != 5'd0) rf[wb_dest] <= wb_data;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          retire   <= 1'b1;
          state    <= FETCH;
        end

        HALT: mem_req <= 1'b0;

        default: state <= HALT;
      endcase
    end
  end

endmodule
